// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nn_pkg
// Description : Shared constants and types for the neural_network output
//               path (probability vector, class index, tracker FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

  localparam int NUM_CLASSES       = 10;
  localparam int PROB_W            = 16;
  localparam int IDX_W             = 4;
  localparam int DEF_STABLE_FRAMES = 3;

  typedef logic [PROB_W-1:0] prob_t;
  typedef logic [IDX_W-1:0]  class_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } tracker_state_t;

endpackage
`default_nettype wire

// File: rtl/nn_result_tracker_stability_filter.sv
`default_nettype none
// ============================================================================
// Module      : nn_result_tracker_stability_filter
// Description : Debounces the per-frame argmax. A class is confirmed only
//               after STABLE_FRAMES consecutive commits agree; a blank
//               (all-zero) frame resets the run but keeps the shown class.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_result_tracker_stability_filter
  import nn_pkg::*;
#(
  parameter int STABLE_FRAMES = DEF_STABLE_FRAMES
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             commit_i,
  input  logic [IDX_W-1:0] argmax_i,
  input  logic             zero_max_i,
  output logic [IDX_W-1:0] stable_class_o,
  output logic             stable_o
);

  localparam logic [3:0] c_stable_frames = 4'(STABLE_FRAMES);

  class_idx_t cand_q, cand_d;
  class_idx_t cls_q, cls_d;
  logic [3:0] count_q, count_d;
  logic       stable_q, stable_d;

  // Next-state of the run-length filter; only a commit strobe changes it.
  always_comb begin
    cand_d   = cand_q;
    count_d  = count_q;
    cls_d    = cls_q;
    stable_d = stable_q;
    if (commit_i) begin
      if (zero_max_i) begin
        cand_d   = '0;
        count_d  = '0;
        stable_d = 1'b0;
      end else if (argmax_i == cand_q) begin
        if (count_q < c_stable_frames) begin
          count_d = count_q + 4'd1;
        end
      end else begin
        cand_d   = argmax_i;
        count_d  = 4'd1;
        stable_d = 1'b0;
      end
      // Reaching the threshold (including the fresh-candidate case when the
      // threshold is 1) confirms the current candidate.
      if (!zero_max_i && (count_d == c_stable_frames)) begin
        cls_d    = cand_d;
        stable_d = 1'b1;
      end
    end
  end

  // Filter state registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cand_q   <= '0;
      count_q  <= '0;
      cls_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      count_q  <= count_d;
      cls_q    <= cls_d;
      stable_q <= stable_d;
    end
  end

  assign stable_class_o = cls_q;
  assign stable_o       = stable_q;

endmodule
`default_nettype wire

// File: rtl/nn_result_tracker.sv
`default_nettype none
// ============================================================================
// Module      : nn_result_tracker
// Description : Snapshots the classifier probability vector on Valid, finds
//               the argmax one class per cycle, debounces the result and
//               builds the 24-bit word for the hex display array.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_result_tracker
  import nn_pkg::*;
#(
  parameter int STABLE_FRAMES = DEF_STABLE_FRAMES
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [PROB_W-1:0] Probability [NUM_CLASSES],
  input  logic [IDX_W-1:0]  Sel,
  input  logic              Sel_max,
  output logic              Busy,
  output logic              Done,
  output logic [IDX_W-1:0]  Argmax,
  output logic [PROB_W-1:0] Max_prob,
  output logic [IDX_W-1:0]  Stable_class,
  output logic              Stable,
  output logic [23:0]       Display
);

  localparam class_idx_t c_last_idx = IDX_W'(NUM_CLASSES - 1);

  tracker_state_t state_q;
  prob_t          snap_q [NUM_CLASSES];
  prob_t          best_val_q;
  class_idx_t     best_idx_q;
  class_idx_t     idx_q;
  prob_t          shown_prob;

  // Snapshot / sequential scan / commit controller with registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      best_val_q <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Argmax     <= '0;
      Max_prob   <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Valid) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              snap_q[i] <= Probability[i];
            end
            best_idx_q <= '0;
            best_val_q <= Probability[0];
            idx_q      <= class_idx_t'(1);
            Busy       <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (snap_q[idx_q] > best_val_q) begin
            best_val_q <= snap_q[idx_q];
            best_idx_q <= idx_q;
          end
          if (idx_q == c_last_idx) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + class_idx_t'(1);
          end
        end
        COMMIT: begin
          Argmax   <= best_idx_q;
          Max_prob <= best_val_q;
          Done     <= 1'b1;
          Busy     <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  nn_result_tracker_stability_filter #(
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_filter (
    .Clk            (Clk),
    .Reset          (Reset),
    .commit_i       (state_q == COMMIT),
    .argmax_i       (best_idx_q),
    .zero_max_i     (best_val_q == '0),
    .stable_class_o (Stable_class),
    .stable_o       (Stable)
  );

  // Probability shown on the low display digits; out-of-range selects read 0.
  always_comb begin
    shown_prob = '0;
    if (Sel_max) begin
      shown_prob = Max_prob;
    end else if ({1'b0, Sel} < (IDX_W + 1)'(NUM_CLASSES)) begin
      shown_prob = snap_q[Sel];
    end
  end

  assign Display = {Stable_class, 4'h0, shown_prob};

endmodule
`default_nettype wire

// File: tb/tb_nn_result_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_result_tracker
// Description : Directed self-checking bench for nn_result_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_result_tracker;

  logic        Clk;
  logic        Reset;
  logic        Valid;
  logic [15:0] Probability [10];
  logic [3:0]  Sel;
  logic        Sel_max;
  logic        Busy;
  logic        Done;
  logic [3:0]  Argmax;
  logic [15:0] Max_prob;
  logic [3:0]  Stable_class;
  logic        Stable;
  logic [23:0] Display;

  int n_cmp;
  int n_fail;

  nn_result_tracker dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Valid        (Valid),
    .Probability  (Probability),
    .Sel          (Sel),
    .Sel_max      (Sel_max),
    .Busy         (Busy),
    .Done         (Done),
    .Argmax       (Argmax),
    .Max_prob     (Max_prob),
    .Stable_class (Stable_class),
    .Stable       (Stable),
    .Display      (Display)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] base);
    for (int i = 0; i < 10; i++) Probability[i] = base;
  endtask

  // Pulse Valid for one edge, then wait (bounded) for Done.
  task automatic run_frame(output int lat, output int busy_cycles);
    Valid = 1'b1;
    tick();
    Valid = 1'b0;
    lat = 0;
    busy_cycles = 0;
    while (Done !== 1'b1 && lat < 30) begin
      if (Busy === 1'b1) busy_cycles++;
      tick();
      lat++;
    end
  endtask

  task automatic peak_frame(input int k, input logic [15:0] v, input string tag);
    int lat, bc;
    fill(16'h0010);
    Probability[k] = v;
    run_frame(lat, bc);
    check({tag, "_latency"}, lat, 10);
    check({tag, "_argmax"}, {28'd0, Argmax}, k);
  endtask

  initial begin
    int lat, bc, dones;
    n_cmp = 0;
    n_fail = 0;
    Reset = 1'b1;
    Valid = 1'b0;
    Sel = 4'd0;
    Sel_max = 1'b0;
    fill(16'h0000);
    tick();
    tick();
    Reset = 1'b0;

    // Reset state
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_argmax", Argmax, 0);
    check("rst_maxprob", Max_prob, 0);
    check("rst_stable_class", Stable_class, 0);
    check("rst_stable", Stable, 0);
    check("rst_display", Display, 0);
    check("rst_count", dut.u_filter.count_q, 0);

    // Basic frame: argmax 3 at 500
    fill(16'h0000);
    Probability[0] = 16'd10;
    Probability[3] = 16'd500;
    Probability[7] = 16'd200;
    run_frame(lat, bc);
    check("a_latency", lat, 10);
    check("a_busy_cycles", bc, 10);
    check("a_busy_at_done", Busy, 0);
    check("a_argmax", Argmax, 3);
    check("a_maxprob", Max_prob, 500);
    check("a_stable", Stable, 0);
    check("a_count", dut.u_filter.count_q, 1);
    tick();
    check("a_done_one_cycle", Done, 0);

    // Display mux against the snapshot
    Sel = 4'd7;
    #1;
    check("disp_sel7", Display, 24'h0000C8);
    Sel = 4'd12;
    #1;
    check("disp_sel12", Display, 24'h000000);
    Sel_max = 1'b1;
    #1;
    check("disp_selmax", Display, 24'h0001F4);
    Sel_max = 1'b0;
    Sel = 4'd0;

    // Tie between classes 2 and 8: lower index wins
    fill(16'h0100);
    Probability[2] = 16'h4000;
    Probability[8] = 16'h4000;
    Probability[5] = 16'h3FFF;
    run_frame(lat, bc);
    check("tie_argmax", Argmax, 2);
    check("tie_maxprob", Max_prob, 16'h4000);

    // Three frames of class 5, then one of class 6
    peak_frame(5, 16'h0900, "s5_1");
    check("s5_1_stable", Stable, 0);
    peak_frame(5, 16'h0900, "s5_2");
    check("s5_2_stable", Stable, 0);
    peak_frame(5, 16'h0900, "s5_3");
    check("s5_3_stable", Stable, 1);
    check("s5_3_class", Stable_class, 5);
    check("s5_3_disp_hi", Display[23:16], 8'h50);
    peak_frame(6, 16'h0900, "s6");
    check("s6_stable", Stable, 0);
    check("s6_class", Stable_class, 5);
    check("s6_disp_hi", Display[23:16], 8'h50);

    // Confirm class 4, blank frame, then reconfirm
    peak_frame(4, 16'h0800, "c4_1");
    peak_frame(4, 16'h0800, "c4_2");
    peak_frame(4, 16'h0800, "c4_3");
    check("c4_stable", Stable, 1);
    check("c4_class", Stable_class, 4);
    fill(16'h0000);
    run_frame(lat, bc);
    check("zero_latency", lat, 10);
    check("zero_stable", Stable, 0);
    check("zero_class", Stable_class, 4);
    check("zero_count", dut.u_filter.count_q, 0);
    check("zero_maxprob", Max_prob, 0);
    peak_frame(4, 16'h0800, "r4_1");
    check("r4_1_stable", Stable, 0);
    peak_frame(4, 16'h0800, "r4_2");
    check("r4_2_stable", Stable, 0);
    peak_frame(4, 16'h0800, "r4_3");
    check("r4_3_stable", Stable, 1);
    check("r4_3_class", Stable_class, 4);

    // Valid during a scan is dropped and the snapshot is untouched
    fill(16'h0010);
    Probability[1] = 16'h0700;
    Valid = 1'b1;
    tick();
    Valid = 1'b0;
    tick();
    tick();
    fill(16'h0020);
    Probability[9] = 16'h7000;
    Valid = 1'b1;
    tick();
    Valid = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (Done === 1'b1) dones++;
      tick();
    end
    check("drop_done_count", dones, 1);
    check("drop_argmax", Argmax, 1);
    check("drop_maxprob", Max_prob, 16'h0700);
    Sel = 4'd9;
    #1;
    check("drop_snap9", Display[15:0], 16'h0010);
    Sel = 4'd0;

    // Reset in the middle of a scan
    fill(16'h0030);
    Probability[6] = 16'h0600;
    Valid = 1'b1;
    tick();
    Valid = 1'b0;
    tick();
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mrst_busy", Busy, 0);
    check("mrst_done", Done, 0);
    check("mrst_argmax", Argmax, 0);
    check("mrst_maxprob", Max_prob, 0);
    check("mrst_stable_class", Stable_class, 0);
    check("mrst_stable", Stable, 0);
    Sel = 4'd6;
    #1;
    check("mrst_display", Display, 0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (Done === 1'b1) dones++;
      tick();
    end
    check("mrst_no_done", dones, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
